// File: rtl/bit_to_byte_fifo_if.sv
// bit_to_byte_fifo_if: serial-bit in / octet-out stream bundle.
//   master: bit source and byte consumer (drives bit_in, bit_in_valid, byte_out_ready)
//   slave : the packer/FIFO (drives byte_out, byte_out_valid, fill_level, overflow, partial_err)
interface bit_to_byte_fifo_if #(parameter int AW = 3);
  logic          bit_in;
  logic          bit_in_valid;
  logic [7:0]    byte_out;
  logic          byte_out_valid;
  logic          byte_out_ready;
  logic [AW:0]   fill_level;
  logic          overflow;
  logic          partial_err;
  modport master (
    output bit_in, bit_in_valid, byte_out_ready,
    input  byte_out, byte_out_valid, fill_level, overflow, partial_err
  );
  modport slave (
    input  bit_in, bit_in_valid, byte_out_ready,
    output byte_out, byte_out_valid, fill_level, overflow, partial_err
  );
endinterface

// File: rtl/bit_to_byte_fifo.sv
// bit_to_byte_fifo: packs an LSB-first bit stream into octets held in a FWFT byte FIFO.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of bit_to_byte_fifo_if (bit input, octet output, status)
module bit_to_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bit_to_byte_fifo_if.slave    bus
);
  logic [2:0]    r_cnt;
  logic [6:0]    r_sreg;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_level;
  logic [7:0]    r_out;
  logic          r_ovf, r_perr;
  logic [7:0]    w_octet, w_out_nxt;
  logic [AW-1:0] w_rp1;
  logic [AW:0]   w_level_nxt;
  logic          w_push, w_pop, w_full, w_wr;
  assign w_octet = {bus.bit_in, r_sreg};
  assign w_push  = bus.bit_in_valid && r_cnt == 3'd7;
  assign w_pop   = r_level != '0 && bus.byte_out_ready;
  assign w_full  = r_level == (AW+1)'(DEPTH);
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_rp1   = r_rp + 1'b1;
  assign w_level_nxt = r_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
  // byte_out is a register that tracks the head: it takes the incoming octet when
  // the FIFO is (or is about to become) empty, the next entry on a pop, else holds.
  always_comb
    w_out_nxt = (r_level == '0 || (w_pop && r_level == (AW+1)'(1))) ? (w_wr ? w_octet : r_out)
              : (w_pop ? r_mem[w_rp1] : r_out);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt   <= '0;
      r_sreg  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (bus.bit_in_valid && r_cnt != 3'd7) r_sreg[r_cnt] <= bus.bit_in;
      r_cnt   <= bus.bit_in_valid ? r_cnt + 3'd1 : 3'd0;
      r_perr  <= !bus.bit_in_valid && r_cnt != 3'd0;
      r_wp    <= w_wr ? r_wp + 1'b1 : r_wp;
      r_rp    <= w_pop ? w_rp1 : r_rp;
      r_level <= w_level_nxt;
      r_ovf   <= r_ovf || (w_push && !w_wr);
      r_out   <= w_out_nxt;
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= w_octet;
  assign bus.byte_out       = r_out;
  assign bus.byte_out_valid = r_level != '0;
  assign bus.fill_level     = r_level;
  assign bus.overflow       = r_ovf;
  assign bus.partial_err    = r_perr;
endmodule
